// File: rtl/sine_tone_gen.sv
// Phase-accumulator sine tone generator: tick-driven DDS with a 2-stage
// table lookup / attenuation pipeline producing unsigned samples.
module sine_tone_gen #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sample_tick,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [1:0]         vol,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_valid,
  output logic               wrap
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int MID   = 1 << (DATA_W - 1);
  localparam int AMP   = MID - 1;
  localparam real TWO_PI = 6.283185307179586;
  localparam logic [DATA_W-1:0]    MID_U = DATA_W'(MID);
  localparam logic signed [DATA_W:0] MID_S = (DATA_W + 1)'(MID);

  // Round-half-up of MID + AMP*sin(2*pi*k/DEPTH), evaluated at elaboration.
  function automatic logic [DATA_W-1:0] rom_entry(input int k);
    real val;
    val = real'(MID) + real'(AMP) * $sin(TWO_PI * real'(k) / real'(DEPTH)) + 0.5;
    return DATA_W'($rtoi($floor(val)));
  endfunction

  logic [DATA_W-1:0] sine_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign sine_rom[k] = rom_entry(k);
  end

  logic [PHASE_W-1:0] acc_q;
  logic [PHASE_W-1:0] acc_d;
  logic               carry_d;
  logic               tick_ok;
  logic               v1_q;
  logic               v2_q;
  logic [DATA_W-1:0]  rom_q;

  logic signed [DATA_W:0] diff;
  logic signed [DATA_W:0] shifted;
  logic signed [DATA_W:0] total;
  logic [DATA_W-1:0]      sample_d;

  always_comb begin
    tick_ok          = sample_tick & enable & ~phase_clr;
    {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, freq_word};
  end

  // Attenuate around the midline; the result always stays inside the sample range.
  always_comb begin
    diff     = $signed({1'b0, rom_q}) - MID_S;
    shifted  = diff >>> vol;
    total    = shifted + MID_S;
    sample_d = total[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q        <= '0;
      wrap         <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      rom_q        <= MID_U;
      sample       <= MID_U;
      sample_valid <= 1'b0;
    end else begin
      wrap         <= 1'b0;
      v1_q         <= tick_ok;
      v2_q         <= v1_q;
      sample_valid <= v2_q;
      if (phase_clr) begin
        acc_q <= '0;
      end else if (tick_ok) begin
        acc_q <= acc_d;
        wrap  <= carry_d;
      end
      if (v1_q) begin
        rom_q <= sine_rom[acc_q[PHASE_W-1 -: ADDR_W]];
      end
      if (v2_q) begin
        sample <= sample_d;
      end
    end
  end

endmodule

// File: tb/tb_sine_tone_gen.sv
// Directed bench for sine_tone_gen: table values, attenuation, wrap, clear,
// enable gating, mid-stream reset and zero-frequency cadence.
module tb_sine_tone_gen;

  localparam int PHASE_W = 16;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               sample_tick;
  logic               phase_clr;
  logic [PHASE_W-1:0] freq_word;
  logic [1:0]         vol;
  logic [DATA_W-1:0]  sample;
  logic               sample_valid;
  logic               wrap;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sq[$];
  int vq[$];
  int wq[$];

  always #5 clk = ~clk;

  sine_tone_gen #(
    .PHASE_W (PHASE_W),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_tick  (sample_tick),
    .phase_clr    (phase_clr),
    .freq_word    (freq_word),
    .vol          (vol),
    .sample       (sample),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  // Monitor on the falling edge: log every valid sample and wrap with a cycle stamp.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sample_valid) begin
      sq.push_back(int'(sample));
      vq.push_back(cyc);
    end
    if (wrap) wq.push_back(cyc);
  end

  task automatic check(input string tag, input int obs, input int req);
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int sget(input int idx);
    return (idx < sq.size()) ? sq[idx] : -1;
  endfunction

  function automatic int vget(input int idx);
    return (idx < vq.size()) ? vq[idx] : -1000;
  endfunction

  task automatic run_stream(input logic [1:0] v, output int base, output int wbase);
    base        = sq.size();
    wbase       = wq.size();
    vol         = v;
    freq_word   = 16'h0800;
    sample_tick = 1'b1;
    step(32);
    sample_tick = 1'b0;
    step(4);
  endtask

  initial begin
    int b;
    int w;
    int bad;

    reset       = 1'b1;
    enable      = 1'b0;
    sample_tick = 1'b0;
    phase_clr   = 1'b0;
    freq_word   = '0;
    vol         = 2'd0;
    step(2);
    check("rst_sample", int'(sample), 8);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_wrap", int'(wrap), 0);
    reset  = 1'b0;
    enable = 1'b1;
    step(1);

    // Full-period stream, no attenuation.
    run_stream(2'd0, b, w);
    check("s0_count", sq.size() - b, 32);
    check("s0_idx1", sget(b + 0), 9);
    check("s0_idx2", sget(b + 1), 11);
    check("s0_idx3", sget(b + 2), 12);
    check("s0_idx4", sget(b + 3), 13);
    check("s0_idx5", sget(b + 4), 14);
    check("s0_idx7", sget(b + 6), 15);
    check("s0_idx8", sget(b + 7), 15);
    check("s0_idx16", sget(b + 15), 8);
    check("s0_idx24", sget(b + 23), 1);
    check("s0_idx0", sget(b + 31), 8);
    check("s0_wraps", wq.size() - w, 1);
    check("s0_wrap_time", (wq.size() > w) ? wq[w] : -1000, vget(b + 31) - 2);
    check("s0_back2back", vget(b + 31) - vget(b), 31);

    run_stream(2'd1, b, w);
    check("v1_idx8", sget(b + 7), 11);
    check("v1_idx24", sget(b + 23), 4);
    check("v1_idx0", sget(b + 31), 8);

    run_stream(2'd2, b, w);
    check("v2_idx8", sget(b + 7), 9);
    check("v2_idx24", sget(b + 23), 6);

    run_stream(2'd3, b, w);
    check("v3_idx8", sget(b + 7), 8);
    check("v3_idx24", sget(b + 23), 7);
    vol = 2'd0;

    // Clear collides with a tick: tick discarded, phase returns to zero.
    freq_word   = 16'h0800;
    sample_tick = 1'b1;
    step(3);
    sample_tick = 1'b0;
    step(3);
    b           = sq.size();
    w           = wq.size();
    phase_clr   = 1'b1;
    sample_tick = 1'b1;
    step(1);
    phase_clr   = 1'b0;
    sample_tick = 1'b0;
    step(3);
    check("clr_no_valid", sq.size() - b, 0);
    check("clr_no_wrap", wq.size() - w, 0);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    check("lat_e0_valid", int'(sample_valid), 0);
    step(1);
    check("lat_e1_valid", int'(sample_valid), 0);
    step(1);
    check("lat_e2_valid", int'(sample_valid), 1);
    check("clr_first", int'(sample), 9);
    step(1);
    check("pulse_end", int'(sample_valid), 0);
    check("sample_hold", int'(sample), 9);

    // Disabled ticks are ignored; a tick just before disable still completes.
    phase_clr = 1'b1;
    step(1);
    phase_clr   = 1'b0;
    b           = sq.size();
    w           = wq.size();
    sample_tick = 1'b1;
    step(1);
    enable    = 1'b0;
    freq_word = 16'hF000;
    step(10);
    sample_tick = 1'b0;
    step(4);
    check("dis_count", sq.size() - b, 1);
    check("dis_last_tick", sget(b), 9);
    check("dis_no_wrap", wq.size() - w, 0);
    enable      = 1'b1;
    freq_word   = 16'h1000;
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    step(3);
    check("dis_acc_held", sget(b + 1), 12);

    // Reset with the pipeline full.
    freq_word   = 16'h0800;
    sample_tick = 1'b1;
    step(5);
    reset       = 1'b1;
    sample_tick = 1'b0;
    #1;
    check("mrst_sample", int'(sample), 8);
    check("mrst_valid", int'(sample_valid), 0);
    check("mrst_wrap", int'(wrap), 0);
    step(2);
    reset = 1'b0;
    b     = sq.size();
    step(4);
    check("mrst_no_valid", sq.size() - b, 0);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    step(3);
    check("mrst_first", sget(b), 9);

    // Zero tuning word, sparse ticks.
    phase_clr = 1'b1;
    step(1);
    phase_clr = 1'b0;
    freq_word = '0;
    b         = sq.size();
    w         = wq.size();
    for (int i = 0; i < 6; i++) begin
      sample_tick = 1'b1;
      step(1);
      sample_tick = 1'b0;
      step(2);
    end
    step(3);
    check("zf_count", sq.size() - b, 6);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (sget(b + i) != 8) bad++;
      if (i > 0 && (vget(b + i) - vget(b + i - 1)) != 3) bad++;
    end
    check("zf_value_spacing", bad, 0);
    check("zf_no_wrap", wq.size() - w, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sine_tone_gen.md
SINE_TONE_GEN -- requirements
Module: sine_tone_gen

Interface
REQ-001 Parameter PHASE_W, default 16: phase accumulator and tuning-word width.
REQ-002 Parameter ADDR_W, default 5: sine table index width; table depth 2^ADDR_W.
REQ-003 Parameter DATA_W, default 4: unsigned sample width; midline MID = 2^(DATA_W-1), amplitude AMP = MID-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  when 0, sample_tick is ignored.
REQ-007 sample_tick  input  1  one-cycle sample-rate strobe; requests one new sample.
REQ-008 phase_clr  input  1  synchronous clear of the phase accumulator.
REQ-009 freq_word  input  PHASE_W  phase increment per accepted tick.
REQ-010 vol  input  2  attenuation, arithmetic right shift of (rom-MID) by 0..3.
REQ-011 sample  output  DATA_W  registered unsigned sine sample.
REQ-012 sample_valid  output  1  one-cycle pulse marking a new sample value.
REQ-013 wrap  output  1  one-cycle pulse when an accepted tick makes the accumulator carry out.

Function
REQ-014 Legal parameters: 2 <= ADDR_W <= PHASE_W, DATA_W >= 2; the block is not required to support other values.
REQ-015 Table entry k = round-half-up(MID + AMP*sin(2*pi*k/2^ADDR_W)), filled at elaboration; defaults give 8 at k=0, 15 at k=8, 1 at k=24.
REQ-016 Accepted tick = sample_tick & enable & !phase_clr, sampled at rising edge E0.
REQ-017 At E0 of an accepted tick: acc <= (acc + freq_word) mod 2^PHASE_W; wrap registered high for one cycle iff carry out.
REQ-018 Stage 1 at E1: rom_q <= table[acc[PHASE_W-1 -: ADDR_W]] using the accumulator value updated at E0.
REQ-019 Stage 2 at E2: sample <= MID + ((signed(rom_q) - MID) >>> vol), vol sampled at E2; sample_valid high for exactly the cycle after E2.
REQ-020 Latency tick-edge to sample_valid: 2 clocks; throughput: one sample per clock with back-to-back ticks.
REQ-021 freq_word is sampled only at E0; changes between ticks affect only later ticks.
REQ-022 phase_clr=1: acc <= 0 at that edge; it has priority over a simultaneous tick, which is discarded (no wrap, no sample_valid for it).
REQ-023 enable=0: acc holds; ticks generate nothing; samples already in stages 1-2 complete normally.
REQ-024 sample holds its last value between sample_valid pulses; wrap and sample_valid are 0 when not pulsing.
REQ-025 The result of the stage-2 shift is always within 0..2^DATA_W-1; no saturation logic is needed.

Reset
REQ-026 While reset=1: acc=0, rom_q=MID, sample=MID, sample_valid=0, wrap=0, all pipeline valid flags=0, applied asynchronously.
REQ-027 Reset asserted mid-stream discards in-flight samples; no sample_valid pulse follows release without a new accepted tick.
REQ-028 After release, the first accepted tick uses acc=0 as its base value.

Verification
REQ-029 Defaults; freq_word=0x0800, vol=0, enable=1, tick every cycle -> samples 9,11,12,13,14,15,15,15 (idx 1..8), ...; 32nd tick gives sample 8 with wrap pulse.
REQ-030 Same stream, vol=1 -> idx 8 gives 11, idx 24 gives 4, idx 0 gives 8.
REQ-031 phase_clr and sample_tick high in the same cycle -> acc=0, no sample_valid 2 clocks later; next tick with freq_word=0x0800 gives 9.
REQ-032 enable=0 with 10 ticks -> no sample_valid, no wrap, acc unchanged; a tick issued 1 cycle before enable fell still produces its sample.
REQ-033 reset pulse with pipeline full -> sample=8, sample_valid=0 immediately; first tick after release (freq_word=0x0800) gives 9.
REQ-034 freq_word=0, ticks every 3 cycles -> sample_valid every 3 cycles, sample constant 8, wrap never asserted.
